bin_to_seg_display: RTL and testbench
=====================================

# bin_to_seg_display

Downstream display stage for the binary conversion game. It accepts a 12-bit binary value (the secret number or the player's guess) and converts it to four BCD digits with a sequential double-dabble engine. It then drives the Nexys A7 4-digit multiplexed seven-segment display with leading-zero blanking. The game core issues a single-cycle `load`; this block owns all BCD conversion, digit scanning and segment decoding.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles each digit stays lit. Must be ≥ 2; the bench uses 4.
- `BLANK_LEADING`, default 1: 1 = blank leading zeros; 0 = always show four digits.

- `clk` in 1: 100 MHz system clock.
- `reset` in 1: asynchronous, active-low reset.
- `value_in` in 12: binary value, 0..4095.
- `load` in 1: single-cycle request to capture `value_in`.
- `busy` out 1: conversion in progress; `load` is ignored while high.
- `seg` out 7: active-low segments {g,f,e,d,c,b,a}, registered.
- `an` out 4: active-low anodes, registered; `an[0]` is the ones digit.

## Operation
- Conversion FSM states: IDLE, SHIFT, COMMIT.
- IDLE:
  - `load`=1 captures `value_in` into a 28-bit scratch register ({16-bit BCD, 12-bit binary}).
  - Clears the iteration counter, sets `busy`=1, and moves to SHIFT.
- SHIFT, once per cycle:
  - Add 3 to every scratch BCD nibble ≥ 5.
  - Then shift the whole scratch register left by 1.
  - After the 12th iteration, move to COMMIT.
- COMMIT: copy the scratch BCD into the display register `disp_bcd` (thousands..ones) in one cycle, clear `busy`, return to IDLE.
- `disp_bcd` changes only in COMMIT. The display shows the previous value for the whole conversion; no partial digits ever appear.
- `load` while `busy`=1 is dropped, not queued.
- Scanner:
  - Free-running counter runs 0..REFRESH_DIV-1.
  - On terminal count it wraps to 0 and digit index `idx` advances 0→1→2→3→0.
  - Scanner runs regardless of FSM state.
- Output register, updated every cycle from `idx` and `disp_bcd`:
  - `an` = active-low one-hot of `idx`.
  - `seg` = decode of the selected digit.
- Decode {g..a}, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any non-BCD nibble=1111111 (cannot occur).
- Blanking (`BLANK_LEADING`=1):
  - Thousands is blank if it is 0.
  - Hundreds is blank if thousands and hundreds are both 0.
  - Tens is blank if the upper three digits are 0.
  - Ones is never blank.
  - A blanked slot drives `an`=1111 and `seg`=1111111.

## Timing
- Reset asserted (asynchronous):
  - `busy`=0, FSM=IDLE, scratch=0, `disp_bcd`=0.
  - Scan counter=0, `idx`=0.
  - `an`=1111, `seg`=1111111.
- First edge after release: `an`=1110, `seg`=1000000 (shows "0").
- Conversion latency, with edge E0 sampling `load`=1 in IDLE:
  - `busy` goes high after E0.
  - E1..E12 perform the 12 shifts.
  - E13 updates `disp_bcd` and drops `busy`.
  - `busy` is therefore high for exactly 13 cycles.
- New digits appear on `seg`/`an` one cycle after E13, for the currently scanned slot.
- A `load` sampled on the edge after E13 (`busy`=0) is accepted. Back-to-back conversions are spaced at 14 cycles minimum.
- `load` sampled at E13 itself is ignored, because `busy` is still 1 during that cycle.
- Scanning:
  - `idx` advances on the edge where counter = REFRESH_DIV-1.
  - `an`/`seg` follow one cycle later.
  - Each digit is lit for exactly REFRESH_DIV cycles; a full frame is 4×REFRESH_DIV cycles.
- Reset mid-conversion: abort immediately, `disp_bcd`=0, `busy`=0. No commit occurs after release.

## Test plan
- Reset low for 5 cycles: `an`=1111, `seg`=1111111, `busy`=0. Release, then 1 edge: `an`=1110, `seg`=1000000.
- REFRESH_DIV=4, `load` 64:
  - `busy` high exactly 13 cycles.
  - Frame afterwards: ones `an`=1110 `seg`=0011001; tens `an`=1101 `seg`=0000010.
  - Hundreds and thousands slots: `an`=1111.
- `load` 4095: slots show 5, 9, 0, 4 (0010010, 0010000, 1000000, 0011001). Hundreds "0" is not blanked; all four anodes are active in turn.
- `load` 8, then `load` 1234 in `busy` cycle 5: after commit the display shows "8" only. `busy` falls 13 cycles after the first `load` with no second conversion.
- `load` 999, then reset low in `busy` cycle 6 and release: `busy`=0, display "0", never 999.
- Previous value is held:
  - `load` 100 commits; then `load` 7 on the first cycle with `busy`=0 is accepted.
  - "100" stays on the display through all 13 `busy` cycles, then switches to "7" with only the ones slot lit.

Source files
------------

// File: rtl/bin_to_seg_display_if.sv
// bin_to_seg_display_if: load/value request from the game core and the display outputs back.
interface bin_to_seg_display_if;
  logic [11:0] value_in;
  logic        load;
  logic        busy;
  logic [6:0]  seg;
  logic [3:0]  an;
  modport master (output value_in, load, input busy, seg, an);
  modport slave  (input value_in, load, output busy, seg, an);
endinterface

// File: rtl/bin_to_seg_display.sv
// bin_to_seg_display: sequential double-dabble to BCD, then a multiplexed 4-digit seven-segment driver.
module bin_to_seg_display #(
  parameter int REFRESH_DIV   = 100000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  bin_to_seg_display_if.slave  bus
);
  localparam int CW = $clog2(REFRESH_DIV);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t         r_state, w_next;
  logic [27:0]    r_scratch;
  logic [3:0]     r_iter;
  logic [15:0]    r_disp_bcd;
  logic [CW-1:0]  r_scan;
  logic [1:0]     r_idx;
  logic [6:0]     r_seg, w_seg;
  logic [3:0]     r_an, w_digit;
  logic [15:0]    w_adj;
  logic           w_tc, w_blank, w_busy;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb
    w_next = r_state == IDLE  ? (bus.load ? SHIFT : IDLE) :
             r_state == SHIFT ? (r_iter == 4'd11 ? COMMIT : SHIFT) : IDLE;
  always_comb w_busy = r_state != IDLE;
  for (genvar i = 0; i < 4; i++) begin : g_adj
    assign w_adj[4*i +: 4] = r_scratch[12+4*i +: 4] >= 4'd5 ? r_scratch[12+4*i +: 4] + 4'd3
                                                             : r_scratch[12+4*i +: 4];
  end
  // disp_bcd is only ever written in COMMIT, so partial digits never reach the display
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_scratch  <= '0;
      r_iter     <= '0;
      r_disp_bcd <= '0;
    end else if (r_state == IDLE && bus.load) begin
      r_scratch <= {16'd0, bus.value_in};
      r_iter    <= '0;
    end else if (r_state == SHIFT) begin
      r_scratch <= {w_adj[14:0], r_scratch[11:0], 1'b0};
      r_iter    <= r_iter + 4'd1;
    end else if (r_state == COMMIT) begin
      r_disp_bcd <= r_scratch[27:12];
    end
  assign w_tc = r_scan == CW'(REFRESH_DIV - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_scan <= '0;
      r_idx  <= '0;
    end else begin
      r_scan <= w_tc ? '0 : r_scan + 1'b1;
      r_idx  <= w_tc ? r_idx + 2'd1 : r_idx;
    end
  assign w_digit = r_disp_bcd[{r_idx, 2'b00} +: 4];
  always_comb begin
    w_seg = 7'b1111111;
    case (w_digit)
      4'd0: w_seg = 7'b1000000;
      4'd1: w_seg = 7'b1111001;
      4'd2: w_seg = 7'b0100100;
      4'd3: w_seg = 7'b0110000;
      4'd4: w_seg = 7'b0011001;
      4'd5: w_seg = 7'b0010010;
      4'd6: w_seg = 7'b0000010;
      4'd7: w_seg = 7'b1111000;
      4'd8: w_seg = 7'b0000000;
      4'd9: w_seg = 7'b0010000;
      default: w_seg = 7'b1111111;
    endcase
  end
  always_comb
    w_blank = BLANK_LEADING && (r_idx == 2'd3 ? r_disp_bcd[15:12] == 4'd0 :
                                r_idx == 2'd2 ? r_disp_bcd[15:8]  == 8'd0 :
                                r_idx == 2'd1 ? r_disp_bcd[15:4]  == 12'd0 : 1'b0);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
    end else begin
      r_an  <= w_blank ? 4'b1111 : ~(4'b0001 << r_idx);
      r_seg <= w_blank ? 7'b1111111 : w_seg;
    end
  assign bus.busy = w_busy;
  assign bus.seg  = r_seg;
  assign bus.an   = r_an;
endmodule

// File: tb/tb_bin_to_seg_display.sv
// tb_bin_to_seg_display: directed scenarios with hand-computed segment patterns, REFRESH_DIV=4.
module tb_bin_to_seg_display;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   passes = 0;
  bin_to_seg_display_if dif();
  bin_to_seg_display #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .reset(reset_n), .bus(dif.slave));
  always #5 clk = ~clk;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000, S9 = 7'b0010000,
                         SB = 7'b1111111;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passes++;
  endtask

  task automatic drive_load(input logic [11:0] v);
    @(negedge clk);
    dif.load = 1'b1;
    dif.value_in = v;
    @(negedge clk);
    dif.load = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (dif.busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input string name, input logic [6:0] e0, e1, e2, e3, input logic [3:0] lit);
    int lit_cnt[4];
    int seg_bad[4];
    int blank_cnt, bad_cnt;
    logic [6:0] exp_s[4];
    exp_s[0] = e0; exp_s[1] = e1; exp_s[2] = e2; exp_s[3] = e3;
    blank_cnt = 0; bad_cnt = 0;
    for (int k = 0; k < 4; k++) begin lit_cnt[k] = 0; seg_bad[k] = 0; end
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (dif.an === 4'b1111) begin
        blank_cnt++;
        if (dif.seg !== SB) bad_cnt++;
      end else begin
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < 4; k++)
          if (dif.an === ~(4'b0001 << k)) begin
            hit = 1'b1;
            lit_cnt[k]++;
            if (dif.seg !== exp_s[k]) seg_bad[k]++;
          end
        if (!hit) bad_cnt++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s slot%0d lit cycles", name, k), lit_cnt[k], lit[k] ? 4 : 0);
      if (lit[k]) chk($sformatf("%s slot%0d seg errors", name, k), seg_bad[k], 0);
    end
    chk({name, " blank/illegal cycles"}, bad_cnt, 0);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    dif.load = 1'b0;
    dif.value_in = '0;
    repeat (5) @(negedge clk);
    chk("reset an", dif.an, 4'b1111);
    chk("reset seg", dif.seg, SB);
    chk("reset busy", dif.busy, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post-reset an", dif.an, 4'b1110);
    chk("post-reset seg", dif.seg, S0);
  endtask

  task automatic test_convert_64;
    int n;
    drive_load(12'd64);
    count_busy(n);
    chk("64 busy cycles", n, 13);
    @(negedge clk);
    check_frame("64", S4, S6, SB, SB, 4'b0011);
  endtask

  task automatic test_convert_4095;
    int n;
    drive_load(12'd4095);
    count_busy(n);
    chk("4095 busy cycles", n, 13);
    @(negedge clk);
    check_frame("4095", S5, S9, S0, S4, 4'b1111);
  endtask

  task automatic test_drop_load;
    int n, extra;
    drive_load(12'd8);
    n = 0;
    while (dif.busy === 1'b1 && n < 40) begin
      n++;
      dif.load = (n == 5);
      dif.value_in = 12'd1234;
      @(negedge clk);
    end
    dif.load = 1'b0;
    chk("drop busy cycles", n, 13);
    extra = 0;
    repeat (20) begin @(negedge clk); if (dif.busy !== 1'b0) extra++; end
    chk("drop no second conversion", extra, 0);
    check_frame("8", S8, SB, SB, SB, 4'b0001);
  endtask

  task automatic test_reset_mid;
    int n, extra;
    drive_load(12'd999);
    n = 1;
    repeat (5) begin @(negedge clk); n++; end
    chk("999 busy before reset", dif.busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid-reset busy", dif.busy, 1'b0);
    chk("mid-reset an", dif.an, 4'b1111);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    extra = 0;
    repeat (20) begin @(negedge clk); if (dif.busy !== 1'b0) extra++; end
    chk("after mid-reset no busy", extra, 0);
    check_frame("abort", S0, SB, SB, SB, 4'b0001);
  endtask

  task automatic test_back_to_back;
    int n, bad;
    drive_load(12'd100);
    count_busy(n);
    chk("100 busy cycles", n, 13);
    dif.load = 1'b1;
    dif.value_in = 12'd7;
    @(negedge clk);
    dif.load = 1'b0;
    n = 0; bad = 0;
    while (dif.busy === 1'b1 && n < 40) begin
      n++;
      if (!((dif.an === 4'b1110 && dif.seg === S0) || (dif.an === 4'b1101 && dif.seg === S0) ||
            (dif.an === 4'b1011 && dif.seg === S1) || (dif.an === 4'b1111 && dif.seg === SB)))
        bad++;
      @(negedge clk);
    end
    chk("7 accepted busy cycles", n, 13);
    chk("100 held during busy", bad, 0);
    @(negedge clk);
    check_frame("7", S7, SB, SB, SB, 4'b0001);
  endtask

  initial begin
    test_reset();
    test_convert_64();
    test_convert_4095();
    test_drop_load();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected done");
    $fatal(1);
  end
endmodule
